// File: rtl/move_decider.sv
// ---------------------------------------------------------------------------
// move_decider
//
// Picks the best first move for one board position by running the Monte-Carlo
// statistics block once per candidate direction (0..3). For each direction
// the statistics block is held in reset for two cycles. It is then released
// until it has accumulated the trial budget, or until a cycle timeout
// expires. The accumulated total move count becomes that direction's score.
// The highest score wins. An equal score is broken by max_move_count, and a
// complete tie keeps the lower direction.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   start, board       decision request (start accepted in IDLE only)
//   busy, done         decision in progress / single-cycle completion pulse
//   best_dir,
//   best_score         result, updated only when done fires
//   timed_out          some direction hit CYC_LIMIT during the last decision
//   stat_rst           synchronous reset for the statistics block
//   restrected         direction currently under evaluation
//   restrect_prob      constant PROB
//   initial_board      board latched at start
//   seed               per-direction seed (SEED ^ dir)
//   total_move_count,
//   total_trial_count,
//   max_move_count     results reported by the statistics block
// ---------------------------------------------------------------------------
module move_decider #(
    parameter int unsigned TRIALS    = 1024,
    parameter logic [31:0] CYC_LIMIT = 32'd50_000_000,
    parameter logic [2:0]  PROB      = 3'd7,
    parameter logic [7:0]  SEED      = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [79:0] board,
    output logic        busy,
    output logic        done,
    output logic [1:0]  best_dir,
    output logic [31:0] best_score,
    output logic        timed_out,
    output logic        stat_rst,
    output logic [1:0]  restrected,
    output logic [2:0]  restrect_prob,
    output logic [79:0] initial_board,
    output logic [7:0]  seed,
    input  logic [31:0] total_move_count,
    input  logic [31:0] total_trial_count,
    input  logic [15:0] max_move_count
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CLR  = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_CAPT = 3'd3;
    localparam logic [2:0] S_NEXT = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam logic [31:0] TRIALS_W = 32'(TRIALS);
    localparam logic [31:0] CYC_LAST = CYC_LIMIT - 32'd1;

    logic [2:0]  state_q, state_d;
    logic [1:0]  dir_q, dir_d;
    logic        clr_cnt_q, clr_cnt_d;
    logic [31:0] cyc_cnt_q, cyc_cnt_d;
    logic [79:0] board_q, board_d;
    logic [1:0]  restr_q, restr_d;
    logic [7:0]  seed_q, seed_d;
    logic        tmo_q, tmo_d;
    logic        best_valid_q, best_valid_d;
    logic [1:0]  cand_dir_q, cand_dir_d;
    logic [31:0] cand_score_q, cand_score_d;
    logic [15:0] cand_max_q, cand_max_d;
    logic [1:0]  out_dir_q, out_dir_d;
    logic [31:0] out_score_q, out_score_d;
    logic [1:0]  dir_inc;
    logic        better;

    assign dir_inc = dir_q + 2'd1;

    // Running best is replaced on: no best yet, strictly higher score, or equal
    // score with strictly higher max_move_count. Anything else keeps the
    // earlier (lower) direction.
    assign better = !best_valid_q
                 || (total_move_count > cand_score_q)
                 || ((total_move_count == cand_score_q) && (max_move_count > cand_max_q));

    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        clr_cnt_d    = clr_cnt_q;
        cyc_cnt_d    = cyc_cnt_q;
        board_d      = board_q;
        restr_d      = restr_q;
        seed_d       = seed_q;
        tmo_d        = tmo_q;
        best_valid_d = best_valid_q;
        cand_dir_d   = cand_dir_q;
        cand_score_d = cand_score_q;
        cand_max_d   = cand_max_q;
        out_dir_d    = out_dir_q;
        out_score_d  = out_score_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    board_d      = board;
                    dir_d        = 2'd0;
                    restr_d      = 2'd0;
                    seed_d       = SEED;
                    tmo_d        = 1'b0;
                    best_valid_d = 1'b0;
                    clr_cnt_d    = 1'b0;
                    cyc_cnt_d    = 32'd0;
                    state_d      = S_CLR;
                end
            end
            S_CLR: begin
                cyc_cnt_d = 32'd0;
                if (clr_cnt_q) begin
                    clr_cnt_d = 1'b0;
                    state_d   = S_RUN;
                end else begin
                    clr_cnt_d = 1'b1;
                end
            end
            S_RUN: begin
                cyc_cnt_d = cyc_cnt_q + 32'd1;
                // The first RUN cycle still shows counts from before the
                // statistics block's synchronous clear, so never trust it.
                if ((cyc_cnt_q != 32'd0) && (total_trial_count >= TRIALS_W)) begin
                    state_d = S_CAPT;
                end else if (cyc_cnt_q == CYC_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = S_CAPT;
                end
            end
            S_CAPT: begin
                if (better) begin
                    cand_dir_d   = dir_q;
                    cand_score_d = total_move_count;
                    cand_max_d   = max_move_count;
                end
                best_valid_d = 1'b1;
                state_d      = S_NEXT;
            end
            S_NEXT: begin
                if (dir_q == 2'd3) begin
                    out_dir_d   = cand_dir_q;
                    out_score_d = cand_score_q;
                    state_d     = S_DONE;
                end else begin
                    dir_d     = dir_inc;
                    restr_d   = dir_inc;
                    seed_d    = SEED ^ {6'd0, dir_inc};
                    clr_cnt_d = 1'b0;
                    state_d   = S_CLR;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            dir_q        <= 2'd0;
            clr_cnt_q    <= 1'b0;
            cyc_cnt_q    <= 32'd0;
            board_q      <= 80'd0;
            restr_q      <= 2'd0;
            seed_q       <= SEED;
            tmo_q        <= 1'b0;
            best_valid_q <= 1'b0;
            cand_dir_q   <= 2'd0;
            cand_score_q <= 32'd0;
            cand_max_q   <= 16'd0;
            out_dir_q    <= 2'd0;
            out_score_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            clr_cnt_q    <= clr_cnt_d;
            cyc_cnt_q    <= cyc_cnt_d;
            board_q      <= board_d;
            restr_q      <= restr_d;
            seed_q       <= seed_d;
            tmo_q        <= tmo_d;
            best_valid_q <= best_valid_d;
            cand_dir_q   <= cand_dir_d;
            cand_score_q <= cand_score_d;
            cand_max_q   <= cand_max_d;
            out_dir_q    <= out_dir_d;
            out_score_q  <= out_score_d;
        end
    end

    assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done          = (state_q == S_DONE);
    assign stat_rst      = (state_q == S_IDLE) || (state_q == S_CLR);
    assign best_dir      = out_dir_q;
    assign best_score    = out_score_q;
    assign timed_out     = tmo_q;
    assign restrected    = restr_q;
    assign restrect_prob = PROB;
    assign initial_board = board_q;
    assign seed          = seed_q;

endmodule

// File: tb/tb_move_decider.sv
module tb_move_decider;

    localparam int          TRIALS    = 4;
    localparam logic [31:0] CYC_LIMIT = 32'd100;
    localparam logic [2:0]  PROB      = 3'd7;
    localparam logic [7:0]  SEED      = 8'hA5;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [79:0] board;
    logic        busy, done, timed_out, stat_rst;
    logic [1:0]  best_dir, restrected;
    logic [31:0] best_score;
    logic [2:0]  restrect_prob;
    logic [79:0] initial_board;
    logic [7:0]  seed;
    logic [31:0] total_move_count, total_trial_count;
    logic [15:0] max_move_count;

    move_decider #(
        .TRIALS(TRIALS), .CYC_LIMIT(CYC_LIMIT), .PROB(PROB), .SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .board(board),
        .busy(busy), .done(done), .best_dir(best_dir), .best_score(best_score),
        .timed_out(timed_out), .stat_rst(stat_rst), .restrected(restrected),
        .restrect_prob(restrect_prob), .initial_board(initial_board), .seed(seed),
        .total_move_count(total_move_count), .total_trial_count(total_trial_count),
        .max_move_count(max_move_count)
    );

    always #5 clk = ~clk;

    // ---------------- statistics block stub ----------------
    logic [31:0] trial_q;
    logic [31:0] totals [4];
    logic [15:0] maxs [4];
    bit          stall_en;
    bit          stale_mode;

    always_ff @(posedge clk) begin
        if (stat_rst)
            trial_q <= 32'd0;
        else if (!(stall_en && restrected == 2'd2 && trial_q >= 32'd3))
            trial_q <= trial_q + 32'd1;
    end

    // In stale mode the stub shows a full budget and a huge score until its
    // first counted trial, so any premature capture is visible.
    assign total_trial_count = (stale_mode && trial_q == 32'd0) ? 32'(TRIALS) : trial_q;
    assign total_move_count  = (stale_mode && trial_q == 32'd0) ? 32'd9999 : totals[restrected];
    assign max_move_count    = (stale_mode && trial_q == 32'd0) ? 16'hFFFF : maxs[restrected];

    // ---------------- model ----------------
    typedef struct {
        bit          rst_chk;
        bit          rst_exp;
        bit          busy;
        bit          done;
        logic [1:0]  restr;
        logic [7:0]  seed;
        bit          tmo;
        logic [1:0]  bdir;
        logic [31:0] bscore;
        bit          first;
    } rec_t;

    rec_t        exp_q[$];
    rec_t        cur;
    logic [1:0]  held_dir;
    logic [31:0] held_score;
    bit          held_tmo;
    logic [79:0] exp_board;
    logic [7:0]  seen_seed[$];
    logic [1:0]  seen_restr[$];
    int          done_cnt;
    int          checks;
    int          errors;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_rec(input bit rc, input bit re, input bit bz, input bit dn,
                            input int d, input bit tmo, input logic [1:0] bd,
                            input logic [31:0] bs, input bit first);
        rec_t r;
        r.rst_chk = rc; r.rst_exp = re; r.busy = bz; r.done = dn;
        r.restr = 2'(d); r.seed = SEED ^ 8'(d); r.tmo = tmo;
        r.bdir = bd; r.bscore = bs; r.first = first;
        exp_q.push_back(r);
    endtask

    // Expected cycle-by-cycle outputs of one decision from its accepting edge.
    task automatic build_decision(input bit stall);
        bit          tmo = 1'b0;
        int          best = 0;
        logic [47:0] best_key = 48'd0;
        int          run_len;
        for (int d = 0; d < 4; d++) begin
            logic [47:0] key = {totals[d], maxs[d]};
            push_rec(1, 1, 1, 0, d, tmo, held_dir, held_score, 1);
            push_rec(1, 1, 1, 0, d, tmo, held_dir, held_score, 0);
            run_len = (stall && d == 2) ? int'(CYC_LIMIT) : TRIALS + 1;
            for (int k = 0; k < run_len; k++)
                push_rec(1, 0, 1, 0, d, tmo, held_dir, held_score, 0);
            if (stall && d == 2) tmo = 1'b1;
            push_rec(0, 0, 1, 0, d, tmo, held_dir, held_score, 0);   // capture
            push_rec(0, 0, 1, 0, d, tmo, held_dir, held_score, 0);   // next
            if (d == 0 || key > best_key) begin
                best = d;
                best_key = key;
            end
        end
        held_dir   = 2'(best);
        held_score = totals[best];
        held_tmo   = tmo;
        push_rec(0, 0, 0, 1, 3, tmo, held_dir, held_score, 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                chk("busy", busy, cur.busy);
                chk("done", done, cur.done);
                if (cur.rst_chk) chk("stat_rst", stat_rst, cur.rst_exp);
                chk("restrected", restrected, cur.restr);
                chk("seed", seed, cur.seed);
                chk("timed_out", timed_out, cur.tmo);
                chk("best_dir", best_dir, cur.bdir);
                chk("best_score", best_score, cur.bscore);
                if (cur.first) begin
                    seen_seed.push_back(seed);
                    seen_restr.push_back(restrected);
                end
            end else begin
                chk("idle_busy", busy, 0);
                chk("idle_done", done, 0);
                chk("idle_stat_rst", stat_rst, 1);
                chk("idle_best_dir", best_dir, held_dir);
                chk("idle_best_score", best_score, held_score);
                chk("idle_timed_out", timed_out, held_tmo);
            end
            chk("restrect_prob", restrect_prob, PROB);
            chk("initial_board", initial_board, exp_board);
            if (done) done_cnt++;
        end
    end

    // ---------------- drivers ----------------
    task automatic set_stub(input logic [31:0] t0, t1, t2, t3,
                            input logic [15:0] m0, m1, m2, m3);
        totals[0] = t0; totals[1] = t1; totals[2] = t2; totals[3] = t3;
        maxs[0] = m0; maxs[1] = m1; maxs[2] = m2; maxs[3] = m3;
    endtask

    task automatic do_start(input logic [79:0] b, input bit stall);
        @(negedge clk); #2;
        board = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        exp_board = b;
        build_decision(stall);
    endtask

    task automatic wait_done();
        int n = 0;
        while (exp_q.size() > 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("decision_complete", 80'(exp_q.size()), 0);
        exp_q.delete();
        @(negedge clk); #2;
    endtask

    task automatic check_result(input string tag, input logic [1:0] d,
                                input logic [31:0] s, input bit t, input int dones);
        chk({tag, "_best_dir"}, best_dir, d);
        chk({tag, "_best_score"}, best_score, s);
        chk({tag, "_timed_out"}, timed_out, t);
        chk({tag, "_done_count"}, 80'(done_cnt), 80'(dones));
    endtask

    initial begin
        int L;
        checks = 0; errors = 0; done_cnt = 0;
        rst = 1'b1; start = 1'b0; board = 80'd0;
        stall_en = 0; stale_mode = 0;
        held_dir = 2'd0; held_score = 32'd0; held_tmo = 0; exp_board = 80'd0;
        set_stub(0, 0, 0, 0, 0, 0, 0, 0);

        // reset state
        #7;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_stat_rst", stat_rst, 1);
        chk("rst_seed", seed, 8'hA5);
        chk("rst_restrected", restrected, 0);
        chk("rst_best_score", best_score, 0);
        chk("rst_initial_board", initial_board, 0);
        @(negedge clk); #2 rst = 1'b0;
        repeat (2) @(negedge clk);

        // T1: clear winner, seed/direction sequence
        seen_seed.delete(); seen_restr.delete();
        set_stub(100, 250, 180, 90, 0, 0, 0, 0);
        do_start(80'h0123_4567_89AB_CDEF_0011, 0);
        chk("t1_latency", 80'(exp_q.size()), 37);
        wait_done();
        check_result("t1", 2'd1, 32'd250, 0, 1);
        chk("t1_seed0", seen_seed[0], 8'hA5);
        chk("t1_seed1", seen_seed[1], 8'hA4);
        chk("t1_seed2", seen_seed[2], 8'hA7);
        chk("t1_seed3", seen_seed[3], 8'hA6);
        chk("t1_restr3", seen_restr[3], 2'd3);

        // T2a: tie on total broken by max; start during DONE is ignored
        set_stub(200, 200, 150, 200, 10, 12, 12, 9);
        do_start(80'h1111_2222_3333_4444_5555, 0);
        L = exp_q.size();
        repeat (L) @(negedge clk);
        #2 board = 80'hDEAD; start = 1'b1;
        @(negedge clk); #2 start = 1'b0;
        wait_done();
        check_result("t2a", 2'd1, 32'd200, 0, 2);

        // T2b: complete tie keeps direction 0
        set_stub(77, 77, 77, 77, 5, 5, 5, 5);
        do_start(80'h2, 0);
        wait_done();
        check_result("t2b", 2'd0, 32'd77, 0, 3);

        // T3: direction 2 stalls and times out
        stall_en = 1;
        set_stub(10, 20, 30, 5, 0, 0, 0, 0);
        do_start(80'h3, 1);
        wait_done();
        stall_en = 0;
        check_result("t3", 2'd2, 32'd30, 1, 4);

        // T4: start pulses while busy are ignored
        set_stub(1, 2, 3, 4, 0, 0, 0, 0);
        do_start(80'h4444_0000_FFFF, 0);
        repeat (5) @(negedge clk);
        #2 board = 80'h9999; start = 1'b1;
        @(negedge clk); #2 start = 1'b0;
        repeat (10) @(negedge clk);
        #2 board = 80'h8888; start = 1'b1;
        @(negedge clk); #2 start = 1'b0;
        wait_done();
        check_result("t4", 2'd3, 32'd4, 0, 5);
        chk("t4_board", initial_board, 80'h4444_0000_FFFF);

        // T5: reset during RUN of direction 1, then a fresh decision
        set_stub(50, 40, 60, 60, 0, 0, 1, 2);
        do_start(80'h5, 0);
        repeat (13) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_stat_rst", stat_rst, 1);
        chk("t5_rst_restrected", restrected, 0);
        chk("t5_rst_seed", seed, 8'hA5);
        chk("t5_rst_board", initial_board, 0);
        chk("t5_rst_best_dir", best_dir, 0);
        exp_q.delete();
        held_dir = 2'd0; held_score = 32'd0; held_tmo = 0; exp_board = 80'd0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_no_done", 80'(done_cnt), 5);
        do_start(80'h5555, 0);
        wait_done();
        check_result("t5", 2'd3, 32'd60, 0, 6);

        // T6: stale counts before the first counted trial must be ignored
        stale_mode = 1;
        set_stub(5, 6, 7, 8, 0, 0, 0, 0);
        do_start(80'h6, 0);
        wait_done();
        stale_mode = 0;
        check_result("t6", 2'd3, 32'd8, 0, 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/move_decider.md
Name: move_decider

Overview:
- Initiator/consumer on the far side of the Monte-Carlo statistics interface.
- For one board position, it runs the statistics block once per candidate first move (4 directions).
- For each direction it waits for a fixed trial budget, then reads the accumulated total move count as that direction's score.
- It returns the best direction to the game controller, sitting between the top-level player FSM and the statistics block.

Parameters:
- TRIALS, 1024: trials per direction; total_trial_count threshold.
- CYC_LIMIT, 32'd50_000_000: per-direction cycle timeout.
- PROB, 3'd7: value driven on restrect_prob.
- SEED, 8'hA5: base seed; per-direction seed is SEED ^ {6'd0, dir}.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; begin a decision on board
- board  in  80  16 cells x 5-bit exponent, latched on accepted start
- busy  out  1  high from accepted start until done
- done  out  1  single-cycle pulse; result valid
- best_dir  out  2  winning direction (0..3), held until next done
- best_score  out  32  winning total move count, held
- timed_out  out  1  set if any direction hit CYC_LIMIT in this decision; held until next start
- stat_rst  out  1  synchronous reset to statistics block
- restrected  out  2  direction under evaluation
- restrect_prob  out  3  constant PROB
- initial_board  out  80  latched board
- seed  out  8  per-direction seed
- total_move_count  in  32  from statistics block
- total_trial_count  in  32  from statistics block
- max_move_count  in  16  from statistics block; used only for tie-break

Behaviour:
- Reset (async): state=IDLE, busy=0, done=0, best_dir=0, best_score=0, timed_out=0, stat_rst=1, restrected=0, initial_board=0, seed=SEED, all counters 0.
- IDLE:
  - stat_rst=1.
  - On start: latch board, dir=0, clear timed_out and best_valid, busy=1, go CLR.
- CLR:
  - stat_rst=1 for exactly 2 cycles; restrected=dir, seed=SEED^dir, cycle counter cleared.
  - Then go RUN.
- RUN:
  - stat_rst=0; cycle counter increments every cycle.
  - Condition "budget reached": total_trial_count >= TRIALS, compared unsigned, full 32 bits.
  - Condition "timeout": counter == CYC_LIMIT-1.
  - If budget reached: go CAPT.
  - Else if timeout: set timed_out, go CAPT.
- CAPT (1 cycle): sample total_move_count and max_move_count.
  - The candidate replaces the best if there is no best yet.
  - Otherwise it replaces the best if its score is strictly greater.
  - Otherwise it replaces the best if the score is equal and its max_move_count is strictly greater (stored 16-bit best_max).
  - On a complete tie, the lower direction wins.
  - Go NEXT.
- NEXT:
  - If dir==3: go DONE.
  - Else dir++, go CLR.
- DONE:
  - Present best_dir/best_score, done=1 for one cycle, busy=0, go IDLE.
- Latency with no timeout: 4x(2 CLR + RUN cycles + 1 CAPT + 1 NEXT) + 1 DONE.
- start while busy: ignored, with no effect on latched board or progress.
- start in the same cycle as DONE: ignored; it is accepted from IDLE only.
- Counts sampled during CLR or the first RUN cycle are never used for capture. RUN requires at least 1 cycle before a budget check, because the statistics block clears its counters synchronously.
- Score arithmetic: 32-bit unsigned compare; no saturation.
- best_dir/best_score change only in DONE; intermediate bests are internal.
- Reset asserted mid-decision: immediate return to the reset state; no done pulse is emitted.

Test Plan:
- Stub stat block reaches TRIALS=4 with totals {100,250,180,90} for dirs 0..3 -> one done pulse, best_dir=1, best_score=250, timed_out=0; restrected sequence 0,1,2,3; seed sequence A5,A4,A7,A6.
- Totals {200,200,150,200} with max {10,12,12,9} -> best_dir=1 (tie on total broken by max); all totals and max equal -> best_dir=0.
- Stub stalls trials at 3 on dir 2, CYC_LIMIT=100 -> dir 2 captured after 100 RUN cycles, timed_out=1, decision still completes with done.
- start pulsed twice while busy, with a different board -> initial_board remains the first board; exactly one done.
- rst asserted during RUN of dir 1 -> outputs return to reset values asynchronously, stat_rst=1, no done; a new start then produces a correct full decision.
- Stale counts: stub holds total_trial_count=TRIALS during CLR -> no capture until RUN; each direction gets 2 stat_rst cycles.
